// File: rtl/sram_client_scheduler.sv
// sram_client_scheduler
//   Shares the single rd/wr requester port of sram_arbiter among NUM_CLIENTS
//   engines. Round-robin grant, one-cycle req pulse per attempt with retry
//   when the arbiter withholds its ack, and a tag FIFO that steers each
//   returning rd_vld/rd_data to the client that issued the read.
// Ports
//   clk_i, reset_L_i         clock, async active-low reset
//   cli_req_i/cli_wr_i       per-client request / 1=write (held until ack)
//   cli_addr_i/cli_wr_data_i packed per-client address / write data
//   cli_ack_o                per-client accept pulse (in the arbiter ack cycle)
//   cli_rd_vld_o/cli_rd_data_o  one-hot read return + shared data bus
//   wr_req_o/wr_addr_o/wr_data_o, rd_req_o/rd_addr_o  to arbiter
//   wr_ack_i/rd_ack_i/rd_vld_i/rd_data_i              from arbiter
//   sched_err_o              sticky: orphan rd_vld or tag FIFO overflow
module sram_client_scheduler #(
    parameter int NUM_CLIENTS     = 4,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int TAG_DEPTH       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_L_i,
    input  logic [NUM_CLIENTS-1:0]                 cli_req_i,
    input  logic [NUM_CLIENTS-1:0]                 cli_wr_i,
    input  logic [NUM_CLIENTS*SRAM_ADDR_WIDTH-1:0] cli_addr_i,
    input  logic [NUM_CLIENTS*SRAM_DATA_WIDTH-1:0] cli_wr_data_i,
    output logic [NUM_CLIENTS-1:0]                 cli_ack_o,
    output logic [NUM_CLIENTS-1:0]                 cli_rd_vld_o,
    output logic [SRAM_DATA_WIDTH-1:0]             cli_rd_data_o,
    output logic                                   wr_req_o,
    output logic [SRAM_ADDR_WIDTH-1:0]             wr_addr_o,
    output logic [SRAM_DATA_WIDTH-1:0]             wr_data_o,
    output logic                                   rd_req_o,
    output logic [SRAM_ADDR_WIDTH-1:0]             rd_addr_o,
    input  logic                                   wr_ack_i,
    input  logic                                   rd_ack_i,
    input  logic                                   rd_vld_i,
    input  logic [SRAM_DATA_WIDTH-1:0]             rd_data_i,
    output logic                                   sched_err_o
);
    localparam int AW = SRAM_ADDR_WIDTH;
    localparam int DW = SRAM_DATA_WIDTH;
    localparam int CW = $clog2(NUM_CLIENTS);
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    // Reset asserts asynchronously, releases two clocks later in this domain.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk_i or negedge reset_L_i) begin
        if (!reset_L_i) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e            state_q, state_d;
    logic [CW-1:0]     rr_q, grant_q, pick_id;
    logic              op_wr_q, pick_vld, ack_ok;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;
    logic [PW:0]       tag_cnt_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     tag_mem [TAG_DEPTH];
    logic              tag_full, push, push_ok, pop;
    logic [NUM_CLIENTS-1:0] rd_vld_q;
    logic [DW-1:0]     rd_data_q;
    logic              err_q;

    // Only one access is ever in flight, so the count seen in IDLE already
    // includes every acked read; no pending-push correction is needed.
    assign tag_full = (tag_cnt_q == (PW+1)'(TAG_DEPTH));
    assign ack_ok   = op_wr_q ? wr_ack_i : rd_ack_i;

    // First eligible client at/after rr_q; reads are skipped while the tag FIFO is full.
    always_comb begin
        int unsigned sum;
        logic [CW-1:0] idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        sum      = 0;
        idx      = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            sum = int'(rr_q) + k;
            if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
            idx = CW'(sum);
            if (!pick_vld && cli_req_i[idx] && (cli_wr_i[idx] || !tag_full)) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = ack_ok ? IDLE : ISSUE;  // no ack: retry same op
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        wr_req_o  = (state_q == ISSUE) &&  op_wr_q;
        rd_req_o  = (state_q == ISSUE) && !op_wr_q;
        cli_ack_o = '0;
        if (state_q == WAIT && ack_ok) cli_ack_o = NUM_CLIENTS'(1) << grant_q;
    end

    assign wr_addr_o     = addr_q;
    assign rd_addr_o     = addr_q;
    assign wr_data_o     = data_q;
    assign cli_rd_vld_o  = rd_vld_q;
    assign cli_rd_data_o = rd_data_q;
    assign sched_err_o   = err_q;

    // Grant latch and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rr_q    <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                grant_q <= pick_id;
                op_wr_q <= cli_wr_i[pick_id];
                addr_q  <= cli_addr_i[int'(pick_id)*AW +: AW];
                data_q  <= cli_wr_data_i[int'(pick_id)*DW +: DW];
            end
            if (state_q == WAIT && ack_ok)
                rr_q <= (grant_q == CW'(NUM_CLIENTS-1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Tag FIFO: a push that finds the FIFO full is dropped unless a pop frees a slot the same cycle.
    assign push    = (state_q == WAIT) && !op_wr_q && rd_ack_i;
    assign pop     = rd_vld_i && (tag_cnt_q != '0);
    assign push_ok = push && (!tag_full || pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) tag_mem[wr_ptr_q] <= grant_q;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_vld_q <= '0;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_vld_q <= NUM_CLIENTS'(1) << tag_mem[rd_ptr_q];
            end
            if (rd_vld_i) rd_data_q <= rd_data_i;
            case ({push_ok, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
            if ((push && !push_ok) || (rd_vld_i && tag_cnt_q == '0)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_client_scheduler.sv
// tb_sram_client_scheduler
//   Directed bench. A single per-cycle step() task plays the arbiter
//   (registered ack one cycle after a req, optional ack withholding, rd_vld
//   return queue) and the clients (drop/advance request on cli_ack), and
//   logs req / ack / read-return events for checking after each scenario.
module tb_sram_client_scheduler;
    localparam int NC = 4, AW = 19, DW = 72, TD = 8;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NC-1:0]     cli_req, cli_wr, cli_ack, cli_rd_vld;
    logic [NC*AW-1:0]  cli_addr;
    logic [NC*DW-1:0]  cli_wr_data;
    logic [DW-1:0]     cli_rd_data, wr_data, rd_data;
    logic              wr_req, rd_req, wr_ack, rd_ack, rd_vld, sched_err;
    logic [AW-1:0]     wr_addr, rd_addr;

    always #5 clk = ~clk;

    sram_client_scheduler #(.NUM_CLIENTS(NC), .SRAM_ADDR_WIDTH(AW),
                            .SRAM_DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk_i(clk), .reset_L_i(reset_L),
        .cli_req_i(cli_req), .cli_wr_i(cli_wr), .cli_addr_i(cli_addr),
        .cli_wr_data_i(cli_wr_data), .cli_ack_o(cli_ack), .cli_rd_vld_o(cli_rd_vld),
        .cli_rd_data_o(cli_rd_data), .wr_req_o(wr_req), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .rd_req_o(rd_req), .rd_addr_o(rd_addr),
        .wr_ack_i(wr_ack), .rd_ack_i(rd_ack), .rd_vld_i(rd_vld), .rd_data_i(rd_data),
        .sched_err_o(sched_err));

    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } req_t;
    typedef struct { int cli; int cyc; } ack_t;
    typedef struct { int cli; logic [DW-1:0] data; } rdv_t;

    req_t req_log[$];
    ack_t ack_log[$];
    rdv_t rdv_log[$];
    logic [AW-1:0] rq[$];

    int n_chk = 0, n_err = 0, cyc = 0, dual_req = 0, multi_vld = 0;
    int rem[NC], done_cnt[NC];
    logic [AW-1:0] base[NC];
    logic [DW-1:0] wdat[NC];
    bit pend_wr, pend_rd, hold_rd, inject;
    logic [AW-1:0] pend_addr;
    int withhold_n;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {8'hD0, 45'd0, a};
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < NC; i++) begin
            cli_req[i] = (rem[i] > 0);
            cli_addr[i*AW +: AW] = base[i] + AW'(done_cnt[i]);
            cli_wr_data[i*DW +: DW] = wdat[i];
        end
    endtask

    // One clock: arbiter responds at the negedge to the req seen one cycle
    // earlier, then (1 time unit later) events are logged and clients react.
    task automatic step();
        @(negedge clk);
        cyc++;
        wr_ack = 1'b0; rd_ack = 1'b0; rd_vld = 1'b0;
        if (inject) begin
            rd_vld = 1'b1; rd_data = 72'hEE; inject = 1'b0;
        end else if (!hold_rd && rq.size() > 0) begin
            rd_vld = 1'b1; rd_data = mkdata(rq.pop_front());
        end
        if (pend_wr || pend_rd) begin
            if (withhold_n > 0) withhold_n--;
            else begin
                wr_ack = pend_wr; rd_ack = pend_rd;
                if (pend_rd) rq.push_back(pend_addr);
            end
        end
        pend_wr = wr_req; pend_rd = rd_req; pend_addr = rd_addr;
        if (wr_req && rd_req) dual_req++;
        if (wr_req || rd_req)
            req_log.push_back('{wr_req, wr_req ? wr_addr : rd_addr, wr_data, cyc});
        #1;
        if ($countones(cli_rd_vld) > 1) multi_vld++;
        for (int i = 0; i < NC; i++) begin
            if (cli_ack[i]) begin
                ack_log.push_back('{i, cyc});
                done_cnt[i]++;
                rem[i]--;
            end
            if (cli_rd_vld[i]) rdv_log.push_back('{i, cli_rd_data});
        end
        drive_clients();
    endtask

    task automatic clear_logs();
        req_log.delete(); ack_log.delete(); rdv_log.delete();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            rem[i] = 0; done_cnt[i] = 0; base[i] = '0; wdat[i] = '0;
        end
        cli_wr = '0; pend_wr = 0; pend_rd = 0; pend_addr = '0;
        hold_rd = 0; inject = 0; withhold_n = 0; rq.delete();
        wr_ack = 0; rd_ack = 0; rd_vld = 0; rd_data = '0;
        drive_clients();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        clear_model();
        repeat (3) step();
        reset_L = 1'b1;
        repeat (4) step();
        clear_logs();
    endtask

    initial begin
        int n1;
        reset_L = 1'b0;
        clear_model();
        repeat (3) step();
        chk("rst_req",  {wr_req, rd_req}, 0);
        chk("rst_cli",  {cli_ack, cli_rd_vld, sched_err}, 0);
        chk("rst_bus",  {wr_addr, rd_addr, cli_rd_data}, 0);
        reset_L = 1'b1;
        repeat (4) step();
        clear_logs();

        // 1: single write from client 0
        base[0] = 19'h00010; wdat[0] = 72'hAB_CDEF_0123_4567_89AB; cli_wr[0] = 1'b1; rem[0] = 1;
        drive_clients();
        repeat (10) step();
        chk("t1_nreq", req_log.size(), 1);
        chk("t1_nack", ack_log.size(), 1);
        if (req_log.size() == 1 && ack_log.size() == 1) begin
            chk("t1_op",   req_log[0].wr, 1);
            chk("t1_addr", req_log[0].addr, 19'h00010);
            chk("t1_data", req_log[0].data, 72'hAB_CDEF_0123_4567_89AB);
            chk("t1_acli", ack_log[0].cli, 0);
            chk("t1_alat", ack_log[0].cyc - req_log[0].cyc, 1);
        end
        chk("t1_nrdv", rdv_log.size(), 0);

        // 2: all four clients read twice each -> round robin 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < NC; i++) begin base[i] = AW'(i * 256); rem[i] = 2; end
        drive_clients();
        repeat (40) step();
        chk("t2_nack", ack_log.size(), 8);
        chk("t2_nrdv", rdv_log.size(), 8);
        if (ack_log.size() == 8 && rdv_log.size() == 8 && req_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("t2_ack%0d", k), ack_log[k].cli, k % 4);
                chk($sformatf("t2_rdv%0d", k), rdv_log[k].cli, k % 4);
            end
            chk("t2_rdat0", rdv_log[0].data, mkdata(19'h000));
            chk("t2_rdat3", rdv_log[3].data, mkdata(19'h300));
            chk("t2_rdat4", rdv_log[4].data, mkdata(19'h001));
            chk("t2_gap",   req_log[1].cyc - req_log[0].cyc, 3);
            chk("t2_gap7",  req_log[7].cyc - req_log[6].cyc, 3);
        end

        // 3: arbiter withholds the first ack -> retry 2 cycles later, one cli_ack
        do_reset();
        withhold_n = 1; base[2] = 19'h00200; rem[2] = 1;
        drive_clients();
        repeat (15) step();
        chk("t3_nreq", req_log.size(), 2);
        chk("t3_nack", ack_log.size(), 1);
        if (req_log.size() == 2 && ack_log.size() == 1) begin
            chk("t3_gap",   req_log[1].cyc - req_log[0].cyc, 2);
            chk("t3_addr0", req_log[0].addr, 19'h00200);
            chk("t3_addr1", req_log[1].addr, 19'h00200);
            chk("t3_rdop",  {req_log[0].wr, req_log[1].wr}, 0);
            chk("t3_acli",  ack_log[0].cli, 2);
        end
        chk("t3_nrdv", rdv_log.size(), 1);
        if (rdv_log.size() == 1) chk("t3_rdv", rdv_log[0].cli, 2);

        // 4: tag FIFO full -> 9th read held, write still granted
        do_reset();
        hold_rd = 1; base[1] = 19'h00100; rem[1] = 9;
        drive_clients();
        repeat (40) step();
        chk("t4_nack8", ack_log.size(), 8);
        chk("t4_nreq8", req_log.size(), 8);
        base[3] = 19'h00300; cli_wr[3] = 1'b1; rem[3] = 1;
        drive_clients();
        repeat (12) step();
        chk("t4_nack9", ack_log.size(), 9);
        if (ack_log.size() == 9) chk("t4_wcli", ack_log[8].cli, 3);
        if (req_log.size() >= 9) chk("t4_wop", req_log[8].wr, 1);
        hold_rd = 0;
        repeat (40) step();
        chk("t4_nack10", ack_log.size(), 10);
        chk("t4_nrdv", rdv_log.size(), 9);
        n1 = 0;
        foreach (rdv_log[k]) if (rdv_log[k].cli == 1) n1++;
        chk("t4_rdvcli", n1, 9);
        if (rdv_log.size() == 9) chk("t4_rdat8", rdv_log[8].data, mkdata(19'h00108));
        chk("t4_err", sched_err, 0);

        // 5: orphan rd_vld -> no cli_rd_vld, sticky sched_err until reset
        inject = 1;
        repeat (4) step();
        chk("t5_nrdv", rdv_log.size(), 9);
        chk("t5_err",  sched_err, 1);
        repeat (5) step();
        chk("t5_sticky", sched_err, 1);
        do_reset();
        chk("t5_clr", sched_err, 0);

        // 6: reset mid-WAIT
        base[2] = 19'h00222; rem[2] = 1;
        drive_clients();
        for (int n = 0; n < 20 && rdv_log.size() == 0; n++) step();
        chk("t6_rd", rdv_log.size(), 1);
        base[0] = 19'h00040; wdat[0] = 72'h11; cli_wr[0] = 1'b1; rem[0] = 1;
        drive_clients();
        for (int n = 0; n < 10 && req_log.size() < 2; n++) step();
        chk("t6_issue", req_log.size(), 2);
        step();
        chk("t6_inwait", cli_ack, 4'b0001);
        reset_L = 1'b0;
        #1;
        chk("t6_ack0",  cli_ack, 0);
        chk("t6_bus0",  {wr_req, rd_req, wr_addr, wr_data}, 0);
        chk("t6_rdat0", cli_rd_data, 0);
        do_reset();
        // rr pointer back at 0: client 0 wins over client 3
        cli_wr = '0; base[0] = 19'h00500; base[3] = 19'h00530; rem[0] = 1; rem[3] = 1;
        drive_clients();
        repeat (20) step();
        chk("t6_nack", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("t6_first",  ack_log[0].cli, 0);
            chk("t6_second", ack_log[1].cli, 3);
        end
        chk("t6_nrdv", rdv_log.size(), 2);
        if (rdv_log.size() == 2) chk("t6_rdv0", rdv_log[0].cli, 0);

        chk("no_dual_req", dual_req, 0);
        chk("onehot_vld",  multi_vld, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
